// File: rtl/qam_demapper_pkg.sv
// Shared definitions for the M-QAM hard-decision demapper.
// Holds the mode encodings, the calibration FSM state type and small helpers
// (binary-to-Gray conversion and per-axis bit count for a given mode).
package qam_demapper_pkg;

  localparam logic [1:0] MODE_QPSK = 2'b00;
  localparam logic [1:0] MODE_16   = 2'b01;
  localparam logic [1:0] MODE_64   = 2'b10;

  typedef enum logic {
    ST_RUN,
    ST_CAL
  } state_t;

  function automatic logic [2:0] gray3(input logic [2:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  // Mode 2'b11 is not a valid constellation and falls back to QPSK.
  function automatic logic [1:0] bits_per_axis(input logic [1:0] m);
    case (m)
      MODE_16: return 2'd2;
      MODE_64: return 2'd3;
      default: return 2'd1;
    endcase
  endfunction

endpackage

// File: rtl/qam_axis_slicer.sv
// Single-axis hard decision for the M-QAM demapper.
// Ports:
//   x     - offset-corrected signed axis value
//   mode  - constellation select (QPSK / 16QAM / 64QAM)
//   code  - Gray-coded level index, right-aligned (only the low nbits are used)
//   nbits - number of bits this axis contributes to the symbol
module qam_axis_slicer
  import qam_demapper_pkg::*;
#(
  parameter int IQ_W = 8,
  parameter int STEP = 16
) (
  input  logic signed [IQ_W-1:0] x,
  input  logic        [1:0]      mode,
  output logic        [2:0]      code,
  output logic        [1:0]      nbits
);

  localparam int AW = IQ_W + 2;

  logic        [1:0]    nb;
  logic signed [AW-1:0] half_span;
  logic signed [AW-1:0] t;
  logic        [AW-1:0] q;
  logic        [AW-1:0] k_max;
  logic        [2:0]    k;

  // Shifting by L*STEP turns the level index into floor(t / (2*STEP)),
  // which is then clamped into [0, L-1].
  always_comb begin
    nb        = bits_per_axis(mode);
    half_span = AW'(STEP << nb);
    k_max     = AW'((1 << nb) - 1);
    t         = $signed({{2{x[IQ_W-1]}}, x}) + half_span;
    q         = '0;
    k         = 3'd0;
    if (!t[AW-1]) begin
      q = $unsigned(t) / AW'(2 * STEP);
      k = (q > k_max) ? k_max[2:0] : q[2:0];
    end
    code  = gray3(k);
    nbits = nb;
  end

endmodule

// File: rtl/qam_demapper_mod.sv
// Hard-decision M-QAM demapper (QPSK / 16QAM / 64QAM, Gray per axis) with
// runtime DC-offset calibration and a gapless MSB-first serial bit output.
// Ports:
//   sclk, rst          - clock (rising edge) and async active-low reset
//   en                 - block enable; gates in_ready only
//   cal                - one-cycle pulse starting an offset calibration
//   mode               - 00 QPSK, 01 16QAM, 10 64QAM, 11 QPSK
//   I_in, Q_in         - signed input samples
//   in_valid/in_ready  - input handshake
//   data_out           - serial bit, valid while data_valid
//   sym_start          - marks the first bit of each symbol
//   cal_busy           - calibration in progress
//
// state  | meaning
// ST_RUN | accepted samples are offset-corrected and demapped
// ST_CAL | accepted samples are accumulated to estimate the I/Q DC offset
module qam_demapper_mod
  import qam_demapper_pkg::*;
#(
  parameter int IQ_W     = 8,
  parameter int STEP     = 16,
  parameter int CAL_LOG2 = 4
) (
  input  logic                   sclk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   cal,
  input  logic        [1:0]      mode,
  input  logic signed [IQ_W-1:0] I_in,
  input  logic signed [IQ_W-1:0] Q_in,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic                   data_out,
  output logic                   data_valid,
  output logic                   sym_start,
  output logic                   cal_busy
);

  localparam int AW = IQ_W + CAL_LOG2;

  state_t                 state;
  logic signed [AW-1:0]   acc_i, acc_q;
  logic signed [AW-1:0]   acc_i_nx, acc_q_nx;
  logic [CAL_LOG2-1:0]    cal_left;
  logic signed [IQ_W-1:0] off_i, off_q;
  logic                   s1_valid;
  logic signed [IQ_W-1:0] s1_i, s1_q;
  logic [1:0]             s1_mode;
  logic [5:0]             shreg;
  logic [2:0]             cnt;
  logic [2:0]             gray_i, gray_q;
  logic [1:0]             nb_i, nb_q;
  logic [5:0]             sym;
  logic [2:0]             sym_len;
  logic                   load;
  logic                   accept;

  function automatic logic signed [IQ_W-1:0] sat_sub(
    input logic signed [IQ_W-1:0] a,
    input logic signed [IQ_W-1:0] b
  );
    logic signed [IQ_W:0] d;
    d = $signed({a[IQ_W-1], a}) - $signed({b[IQ_W-1], b});
    if (d[IQ_W] != d[IQ_W-1])
      return d[IQ_W] ? {1'b1, {(IQ_W-1){1'b0}}} : {1'b0, {(IQ_W-1){1'b1}}};
    return d[IQ_W-1:0];
  endfunction

  qam_axis_slicer #(.IQ_W(IQ_W), .STEP(STEP)) u_slice_i (
    .x     (s1_i),
    .mode  (s1_mode),
    .code  (gray_i),
    .nbits (nb_i)
  );

  qam_axis_slicer #(.IQ_W(IQ_W), .STEP(STEP)) u_slice_q (
    .x     (s1_q),
    .mode  (s1_mode),
    .code  (gray_q),
    .nbits (nb_q)
  );

  // Symbol is MSB-aligned in the shift register: I bits then Q bits.
  always_comb begin
    case (s1_mode)
      MODE_16: sym = {gray_i[1:0], gray_q[1:0], 2'b00};
      MODE_64: sym = {gray_i, gray_q};
      default: sym = {gray_i[0], gray_q[0], 4'b0000};
    endcase
    sym_len = {1'b0, nb_i} + {1'b0, nb_q};
  end

  // Loading while the last bit is on the wire keeps symbols back-to-back.
  assign load       = s1_valid && (cnt <= 3'd1);
  // rst term forces in_ready low during reset even with en high.
  assign in_ready   = rst && en && (!s1_valid || load);
  assign accept     = in_valid && in_ready;
  assign acc_i_nx   = acc_i + AW'(I_in);
  assign acc_q_nx   = acc_q + AW'(Q_in);
  assign data_out   = shreg[5];
  assign data_valid = (cnt != 3'd0);
  assign cal_busy   = (state == ST_CAL);

  always_ff @(posedge sclk or negedge rst) begin
    if (!rst) begin
      state     <= ST_RUN;
      acc_i     <= '0;
      acc_q     <= '0;
      cal_left  <= '0;
      off_i     <= '0;
      off_q     <= '0;
      s1_valid  <= 1'b0;
      s1_i      <= '0;
      s1_q      <= '0;
      s1_mode   <= MODE_QPSK;
      shreg     <= '0;
      cnt       <= 3'd0;
      sym_start <= 1'b0;
    end else begin
      if (load) begin
        shreg <= sym;
        cnt   <= sym_len;
      end else if (cnt != 3'd0) begin
        shreg <= {shreg[4:0], 1'b0};
        cnt   <= cnt - 3'd1;
      end
      sym_start <= load;

      if (accept && state == ST_RUN) begin
        s1_valid <= 1'b1;
        s1_i     <= sat_sub(I_in, off_i);
        s1_q     <= sat_sub(Q_in, off_q);
        s1_mode  <= mode;
      end else if (load) begin
        s1_valid <= 1'b0;
      end

      case (state)
        ST_RUN: begin
          if (cal) begin
            state    <= ST_CAL;
            acc_i    <= '0;
            acc_q    <= '0;
            cal_left <= '1;
          end
        end
        ST_CAL: begin
          if (accept) begin
            acc_i <= acc_i_nx;
            acc_q <= acc_q_nx;
            if (cal_left == '0) begin
              off_i <= IQ_W'(acc_i_nx >>> CAL_LOG2);
              off_q <= IQ_W'(acc_q_nx >>> CAL_LOG2);
              state <= ST_RUN;
            end else begin
              cal_left <= cal_left - 1'b1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_qam_demapper_mod.sv
module tb_qam_demapper_mod;

  localparam int IQ_W     = 8;
  localparam int STEP     = 16;
  localparam int CAL_LOG2 = 2;
  localparam int NCAL     = 1 << CAL_LOG2;

  logic                   sclk = 1'b0;
  logic                   rst = 1'b0;
  logic                   en = 1'b0;
  logic                   cal = 1'b0;
  logic [1:0]             mode = 2'b00;
  logic signed [IQ_W-1:0] I_in = '0;
  logic signed [IQ_W-1:0] Q_in = '0;
  logic                   in_valid = 1'b0;
  logic                   in_ready;
  logic                   data_out;
  logic                   data_valid;
  logic                   sym_start;
  logic                   cal_busy;

  qam_demapper_mod #(.IQ_W(IQ_W), .STEP(STEP), .CAL_LOG2(CAL_LOG2)) dut (
    .sclk       (sclk),
    .rst        (rst),
    .en         (en),
    .cal        (cal),
    .mode       (mode),
    .I_in       (I_in),
    .Q_in       (Q_in),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .data_out   (data_out),
    .data_valid (data_valid),
    .sym_start  (sym_start),
    .cal_busy   (cal_busy)
  );

  always #5 sclk = ~sclk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    bit b;
    bit first;
    int avail;
  } mbit_t;

  mbit_t mq[$];
  int    e_idx = 0;
  bit    m_cal = 0;
  int    m_acc_i = 0, m_acc_q = 0, m_n = 0;
  int    m_off_i = 0, m_off_q = 0;
  bit    exp_dv = 0, exp_do = 0, exp_ss = 0;

  function automatic int nb_of(input int m);
    if (m == 1) return 2;
    if (m == 2) return 3;
    return 1;
  endfunction

  // Level index = number of decision thresholds at or below x.
  function automatic int axis_k(input int x, input int nb);
    int lv = 1 << nb;
    int k = 0;
    for (int j = 0; j < lv - 1; j++)
      if (x >= (2 * j - lv + 2) * STEP) k++;
    return k;
  endfunction

  function automatic int sat8(input int v);
    if (v > 127) return 127;
    if (v < -128) return -128;
    return v;
  endfunction

  function automatic int fdiv(input int a, input int d);
    if (a >= 0) return a / d;
    return -((-a + d - 1) / d);
  endfunction

  function automatic int model_code(input int m, input int i, input int q);
    int nb = nb_of(m);
    int ki = axis_k(i, nb);
    int kq = axis_k(q, nb);
    return ((ki ^ (ki >> 1)) << nb) | (kq ^ (kq >> 1));
  endfunction

  task automatic push_sym(input int m, input int i, input int q, input int avail);
    int    code;
    int    n;
    mbit_t t;
    code = model_code(m, sat8(i - m_off_i), sat8(q - m_off_q));
    n = 2 * nb_of(m);
    for (int b = n - 1; b >= 0; b--) begin
      t.b = code[b];
      t.first = (b == n - 1);
      t.avail = avail;
      mq.push_back(t);
    end
  endtask

  always @(negedge sclk) begin
    bit exp_rdy;
    bit was_cal;
    int pend;
    if (!rst) begin
      mq.delete();
      m_cal = 0; m_acc_i = 0; m_acc_q = 0; m_n = 0;
      m_off_i = 0; m_off_q = 0;
      exp_dv = 0; exp_do = 0; exp_ss = 0;
      chk("rst_data_valid", data_valid, 0);
      chk("rst_in_ready", in_ready, 0);
    end else begin
      chk("data_valid", data_valid, exp_dv);
      chk("sym_start", sym_start, exp_ss);
      chk("cal_busy", cal_busy, m_cal);
      if (exp_dv) chk("data_out", data_out, exp_do);
      pend = 0;
      foreach (mq[j]) if (mq[j].first) pend++;
      exp_rdy = en && ((pend == 0) || mq[0].first);
      chk("in_ready", in_ready, exp_rdy);
      was_cal = m_cal;
      if (in_valid && exp_rdy) begin
        if (m_cal) begin
          m_acc_i += int'(I_in);
          m_acc_q += int'(Q_in);
          m_n++;
          if (m_n == NCAL) begin
            m_off_i = fdiv(m_acc_i, NCAL);
            m_off_q = fdiv(m_acc_q, NCAL);
            m_cal = 0;
          end
        end else begin
          push_sym(int'(mode), int'(I_in), int'(Q_in), e_idx + 2);
        end
      end
      if (!was_cal && cal) begin
        m_cal = 1; m_acc_i = 0; m_acc_q = 0; m_n = 0;
      end
      if (mq.size() > 0 && mq[0].avail <= e_idx + 1) begin
        exp_dv = 1;
        exp_do = mq[0].b;
        exp_ss = mq[0].first;
        void'(mq.pop_front());
      end else begin
        exp_dv = 0; exp_do = 0; exp_ss = 0;
      end
    end
    e_idx++;
  end

  bit stream_mon = 0;
  int stream_gaps = 0;
  always @(negedge sclk)
    if (stream_mon && rst && !data_valid) stream_gaps++;

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge sclk);
    #1;
  endtask

  task automatic send(input int m, input int i, input int q);
    int w;
    mode = 2'(m);
    I_in = IQ_W'(i);
    Q_in = IQ_W'(q);
    in_valid = 1'b1;
    w = 0;
    @(negedge sclk);
    while (!in_ready && w < 60) begin
      @(negedge sclk);
      w++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout at %0t: in_ready stayed 0, expected 1", $time);
    end
    @(posedge sclk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic cal_pulse();
    cal = 1'b1;
    tick(1);
    cal = 1'b0;
  endtask

  task automatic expect_bits(input int n, input int lit, input string name);
    int w;
    int got;
    w = 0;
    got = 0;
    @(negedge sclk);
    while (!(data_valid === 1'b1 && sym_start === 1'b1) && w < 40) begin
      @(negedge sclk);
      w++;
    end
    if (!(data_valid === 1'b1 && sym_start === 1'b1)) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout at %0t: no symbol start, expected one", name, $time);
    end else begin
      for (int b = 0; b < n; b++) begin
        got = (got << 1) | int'(data_out);
        if (b < n - 1) @(negedge sclk);
      end
      chk(name, got, lit);
    end
    @(posedge sclk);
    #1;
  endtask

  initial begin
    chk("model_16qam", model_code(1, 48, -16), 32'b1001);
    chk("model_64_sat", model_code(2, 127, -128), 32'b100000);
    chk("model_64_zero", model_code(2, 0, -1), 32'b110010);
    chk("model_qpsk_cal", model_code(0, 26 - 10, -22 + 6), 32'b10);

    // reset state
    tick(3);
    chk("init_data_out", data_out, 0);
    chk("init_data_valid", data_valid, 0);
    chk("init_sym_start", sym_start, 0);
    chk("init_cal_busy", cal_busy, 0);
    chk("init_in_ready", in_ready, 0);
    rst = 1'b1;
    en = 1'b1;
    tick(2);

    // 16QAM and 64QAM decisions
    send(1, 48, -16); idle();
    expect_bits(4, 32'b1001, "qam16_bits");
    tick(3);
    send(2, 127, -128); idle();
    expect_bits(6, 32'b100000, "qam64_sat");
    tick(2);
    send(2, 0, -1); idle();
    expect_bits(6, 32'b110010, "qam64_zero");
    tick(2);

    // calibration (offsets 10 / -6)
    cal_pulse();
    chk("cal_busy_start", cal_busy, 1);
    for (int s = 0; s < NCAL; s++) begin
      send(0, 10, -6); idle();
      chk("cal_busy_count", cal_busy, (s < NCAL - 1) ? 1 : 0);
    end
    send(0, 26, -22); idle();
    expect_bits(2, 32'b10, "cal_qpsk_a");
    tick(2);
    send(0, 5, -10); idle();
    expect_bits(2, 32'b00, "cal_qpsk_b");
    tick(2);

    // negative accumulation floors: I sum -7 -> -2, Q sum 13 -> 3
    cal_pulse();
    send(0, -1, 3); send(0, -2, 3); send(0, -2, 3); send(0, -2, 4); idle();
    send(0, -2, 2); idle();
    expect_bits(2, 32'b10, "cal_floor");
    tick(2);

    // reset mid-run clears offsets and in-flight symbols
    cal_pulse();
    for (int s = 0; s < NCAL; s++) send(0, 20, 0);
    idle();
    send(1, 100, 100); send(1, -100, 50);
    #2 rst = 1'b0;
    #1;
    chk("midrst_data_out", data_out, 0);
    chk("midrst_data_valid", data_valid, 0);
    chk("midrst_sym_start", sym_start, 0);
    chk("midrst_cal_busy", cal_busy, 0);
    chk("midrst_in_ready", in_ready, 0);
    idle();
    tick(2);
    rst = 1'b1;
    tick(1);
    send(1, 48, -16); idle();
    expect_bits(4, 32'b1001, "post_rst_offsets");
    tick(3);

    // gapless streaming, QPSK then 64QAM mid-stream
    stream_gaps = 0;
    for (int s = 0; s < 8; s++) begin
      case (s % 4)
        0: send(0, 40, 40);
        1: send(0, -40, 40);
        2: send(0, 40, -40);
        default: send(0, -40, -40);
      endcase
      if (s == 2) stream_mon = 1;
    end
    send(2, 90, -50); send(2, -20, 33); send(2, 5, -70); send(2, -110, 60);
    stream_mon = 0;
    idle();
    chk("stream_gaps", stream_gaps, 0);
    tick(30);

    // en low while a 6-bit symbol drains
    send(2, -100, 70);
    en = 1'b0;
    mode = 2'd2; I_in = 8'sd1; Q_in = 8'sd1;
    expect_bits(6, 32'b000101, "en_low_drain");
    chk("en_low_ready", in_ready, 0);
    tick(3);
    chk("en_low_ready_late", in_ready, 0);
    en = 1'b1;
    send(2, 1, 1); idle();
    expect_bits(6, 32'b110110, "en_resume");
    tick(2);

    // en low during calibration holds the sample count
    cal_pulse();
    send(0, 8, 8); send(0, 8, 8);
    en = 1'b0;
    tick(5);
    chk("cal_hold_busy", cal_busy, 1);
    en = 1'b1;
    send(0, 8, 8);
    chk("cal_hold_busy_3", cal_busy, 1);
    send(0, 8, 8); idle();
    chk("cal_hold_done", cal_busy, 0);
    send(0, 7, 8); idle();
    expect_bits(2, 32'b01, "cal_hold_offsets");
    tick(10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog at %0t: simulation did not finish, expected completion", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/qam_demapper_mod.md
Name: qam_demapper_mod

Overview:
- Parametrised hard-decision M-QAM demapper: selectable QPSK/16QAM/64QAM per symbol, Gray-coded per axis.
- Adds a runtime DC-offset calibration and a gapless serial bit output with a valid/ready input handshake.
- Sits between the I/Q sample front end and the serial data sink; it is the successor of the fixed 16QAM demapper.
- Single clock domain.

Parameters:
- IQ_W, 8: signed width of I_in/Q_in.
- STEP, 16: half decision spacing. Per-axis ideal levels are ±1,±3,±5,±7 × STEP; thresholds are at 0, ±2, ±4, ±6 × STEP.
- CAL_LOG2, 4: calibration averages 2^CAL_LOG2 accepted samples.

Ports:
- sclk, in, 1: symbol/system clock, rising edge.
- rst, in, 1: reset. One clock; reset is asynchronous and active-low.
- en, in, 1: block enable. When low, in_ready=0; serializer keeps draining; calibration count holds.
- cal, in, 1: 1-cycle pulse that starts calibration.
- mode, in, 2: 00=QPSK, 01=16QAM, 10=64QAM, 11 treated as QPSK.
- I_in, in, IQ_W: signed I sample.
- Q_in, in, IQ_W: signed Q sample.
- in_valid, in, 1: sample valid.
- in_ready, out, 1: sample accepted on an edge where in_valid && in_ready.
- data_out, out, 1: serial bit, MSB first.
- data_valid, out, 1: data_out is meaningful.
- sym_start, out, 1: high with the first bit of each symbol.
- cal_busy, out, 1: calibration in progress.

Behaviour:
- Reset (async, rst=0):
  - Outputs: data_out=0, data_valid=0, sym_start=0, cal_busy=0, in_ready=0.
  - Internal: offsets=0, S1 empty, serializer count=0, FSM=RUN, accumulators=0.
- FSM RUN:
  - cal=1 goes to CAL; clear accumulators and sample count.
- FSM CAL:
  - cal_busy=1. Accepted samples go to the accumulators (width IQ_W+CAL_LOG2, signed) and are not demapped.
  - After the 2^CAL_LOG2-th accepted sample:
    - offI = accI >>> CAL_LOG2, same for Q (arithmetic shift, floor).
    - Return to RUN.
  - cal during CAL is ignored.
  - Serializer and S1 drain normally during CAL.
- Stage S1, on acceptance in RUN:
  - Store Ic = sat(I_in − offI) and Qc = sat(Q_in − offQ), saturated to the IQ_W signed range.
  - Store a mode snapshot. Mode is per-symbol; changing mode mid-stream affects only later accepted symbols.
- Decision, combinational S1 → serializer:
  - L = 2/4/8 levels per axis; b = 1/2/3 bits per axis.
  - k = clamp(floor((x + L·STEP)/(2·STEP)), 0, L−1), computed at width IQ_W+2.
  - Axis bits = Gray(k), MSB first. Symbol = I bits then Q bits (2/4/6 bits).
- Serializer:
  - Shift register of 6 bits; cnt = remaining bits.
  - data_valid = (cnt≠0). data_out = shift-register MSB.
  - Each clock with cnt≠0: shift and decrement cnt.
  - Load when s1_valid && cnt≤1. This gives gapless back-to-back symbols; a load overrides the shift.
  - sym_start=1 in the first cycle after a load.
- Handshake: in_ready = en && (!s1_valid || load_this_cycle). This applies in both RUN and CAL.
- Latency: accepted at edge N → first bit valid after edge N+1 (when serializer idle).
- Throughput: one symbol per 2b cycles at steady state; data_valid stays continuously high.
- Reset mid-operation: all in-flight symbols are discarded, offsets cleared, outputs return to reset values asynchronously.

Decomposition:
- Package qam_demapper_pkg holds:
  - mode encodings (MODE_QPSK, MODE_16, MODE_64);
  - FSM state enum (ST_RUN, ST_CAL);
  - function gray3 (binary→Gray);
  - function bits_per_axis(mode).
- One natural sub-module, qam_axis_slicer (parameters IQ_W, STEP): corrected axis value + mode → 3-bit Gray code and bit count. It is instantiated twice, for I and Q.

Test Plan (IQ_W=8, STEP=16, CAL_LOG2=2):
1. Reset: assert rst=0 mid-run → data_valid=0, data_out=0, sym_start=0, cal_busy=0, in_ready=0 immediately. Release, then send 16QAM I=48,Q=−16 → shows offsets are 0.
2. 16QAM, I=48 (k=3, Gray 10), Q=−16 (k=1, Gray 01) → data_out 1,0,0,1 on the 4 cycles after edge N+1. sym_start on the first bit only.
3. 64QAM boundary/saturation: I=127 (k=7, Gray 100), Q=−128 (k=0, Gray 000) → bits 1,0,0,0,0,0. Also I=0 gives k=4 (Gray 110); I=−1 gives k=3 (Gray 010).
4. Calibration: cal pulse, then 4 samples I=10,Q=−6 → cal_busy high for exactly 4 accepts, no data_valid. Then QPSK I=26,Q=−22 → bits 1,0.
5. Streaming: continuous QPSK in_valid with alternating patterns → in_ready high every 2nd cycle, data_valid continuously high, no bit gaps. Switching mode to 64QAM mid-stream applies from the next accepted symbol.
6. Back-pressure: en=0 while the serializer holds a 6-bit symbol → serializer drains all 6 bits, in_ready=0. With en=0 during CAL, the sample count holds until en returns.
